button_debounce_multi: RTL and testbench
========================================

Name: button_debounce_multi

Overview:
Parametrised multi-channel push-button conditioner that replaces single-button debounce logic in top-level glue. Each channel has the following stages:
- 2-FF synchroniser on the raw pin.
- Polarity normalisation.
- Counter-based debounce.
- Single-cycle press/release event pulses.
- Long-press detection with an optional auto-repeat mode.

Outputs drive start strobes for bus masters such as the I2C writer, and status LEDs.

Parameters:
N_CH, 4, number of independent button channels (1..32)
DEB_CYCLES, 65536, cycles the synchronised level must differ from the stable level before it is accepted (>=2)
DEB_W, 17, width of debounce counter; must satisfy 2**DEB_W > DEB_CYCLES-1
LONG_CYCLES, 25000000, cycles a stable press must persist to flag a long press (>=2)
LONG_W, 25, width of hold counter; must satisfy 2**LONG_W > max(LONG_CYCLES, REPEAT_CYCLES)-1
ACTIVE_LOW, 1, 1 = raw pin reads 0 when pressed; 0 = reads 1 when pressed
REPEAT_EN, 0, 1 = emit repeated press_o pulses while held past long press
REPEAT_CYCLES, 5000000, period of auto-repeat pulses (>=2)

Ports:
clk  input  1  system clock, all logic on rising edge
rst_n  input  1  asynchronous active-low reset
btn_raw  input  N_CH  raw button pins, asynchronous to clk
level_o  output  N_CH  debounced level per channel, 1 = pressed
press_o  output  N_CH  1-cycle pulse on accepted press (and on each auto-repeat)
release_o  output  N_CH  1-cycle pulse on accepted release
long_o  output  N_CH  1-cycle pulse when press held LONG_CYCLES
any_pressed_o  output  1  OR of level_o

Behaviour:
- Reset, asynchronous on rst_n low:
  - sync flops load the inactive raw level (ACTIVE_LOW ? 1 : 0).
  - stable = 0.
  - debounce and hold counters = 0; long_done = 0.
  - all outputs 0.
  - Reset asserted mid-debounce or mid-hold discards all progress. No pulse is emitted on reset exit, even if a button is held. A held button is accepted DEB_CYCLES+2 cycles after rst_n deassert, as a normal press.
- Normalisation: nrm = sync2 XOR ACTIVE_LOW, so 1 = pressed.
- Debounce, per channel, each cycle:
  - if nrm == stable: deb_cnt <= 0.
  - else if deb_cnt == DEB_CYCLES-1: stable <= nrm, deb_cnt <= 0, and a press or release pulse is issued that same cycle (registered, visible the next cycle).
  - else: deb_cnt <= deb_cnt+1.
- Debounce latency: a raw change held steady shows on level_o exactly DEB_CYCLES+2 rising edges after the first edge that samples the new level.
- Glitch rule: any return to the stable level before acceptance clears the counter. The next change restarts the count from 0.
- Pulse outputs: press_o, release_o and long_o are registered, high for exactly one cycle, and mutually exclusive per channel in any cycle.
- Hold counter, per channel:
  - clears on the cycle stable goes 1, and whenever stable == 0.
  - while stable == 1, increments and saturates at all-ones.
  - when hold_cnt reaches LONG_CYCLES-1: long_o pulses once and long_done <= 1.
  - long_done clears on release.
- Auto-repeat (REPEAT_EN = 1):
  - after the long_o pulse, hold_cnt is reused as the repeat timer: it restarts at 0 the cycle after long_o.
  - each time it reaches REPEAT_CYCLES-1, press_o pulses and the counter restarts at 0.
  - release stops repeats immediately; no pulse is issued in the release cycle except release_o.
- REPEAT_EN = 0: at most one press_o per accepted press.
- Channels are fully independent; simultaneous events on different channels each pulse in the same cycle.
- any_pressed_o is combinational from the level_o register (no added latency).
- Counter widths are fixed by DEB_W/LONG_W; no wrap occurs inside the legal parameter range.

Test Plan:
Common sim parameters: N_CH=4, DEB_CYCLES=16, LONG_CYCLES=64, REPEAT_CYCLES=20, ACTIVE_LOW=1.
1. Reset, then btn_raw[0] 1->0 held -> level_o[0] rises exactly 18 edges later; press_o[0] high 1 cycle; other channels 0; any_pressed_o = 1.
2. btn_raw[1] low for 10 cycles then high, repeated 5 times -> level_o[1], press_o[1] and release_o[1] stay 0 throughout.
3. Hold ch2 with REPEAT_EN=0 for 200 cycles after acceptance -> press_o[2] once, long_o[2] once at hold cycle 64, no further pulses; on release -> release_o[2] once after 18 cycles, level_o[2] = 0.
4. REPEAT_EN=1, hold ch3 for 150 cycles after long_o -> press_o[3] pulses every 20 cycles (7 pulses); release -> repeats stop, single release_o[3].
5. ch0 and ch3 press at the same edge -> press_o[0] and press_o[3] high in the same cycle.
6. rst_n pulsed low during debounce count 10 of ch0 -> no pulses; count restarts; press accepted 18 cycles after rst_n high if still held.

Source files
------------

// File: rtl/button_debounce_multi_if.sv
// Button conditioner bus.
// Carries the raw button pins toward the conditioner and its per-channel
// outputs away from it.
//   btn_raw       : raw pins, asynchronous to the conditioner clock
//   level_o       : debounced level per channel, 1 = pressed
//   press_o       : one-cycle pulse on an accepted press or an auto-repeat
//   release_o     : one-cycle pulse on an accepted release
//   long_o        : one-cycle pulse when a press has been held long enough
//   any_pressed_o : OR of level_o
// The master drives the pins; the slave is the conditioner.
interface button_debounce_multi_if #(
  parameter int N_CH = 4
);
  logic [N_CH-1:0] btn_raw;
  logic [N_CH-1:0] level_o;
  logic [N_CH-1:0] press_o;
  logic [N_CH-1:0] release_o;
  logic [N_CH-1:0] long_o;
  logic            any_pressed_o;

  modport master (
    output btn_raw,
    input  level_o, press_o, release_o, long_o, any_pressed_o
  );

  modport slave (
    input  btn_raw,
    output level_o, press_o, release_o, long_o, any_pressed_o
  );
endinterface

// File: rtl/button_debounce_multi.sv
// Multi-channel push-button conditioner.
// Each channel goes through these stages:
//   - a 2-FF synchroniser
//   - polarity normalisation
//   - a counter-based debounce
//   - registered single-cycle press/release pulses
//   - long-press detection with optional auto-repeat
// Ports:
//   clk   : system clock, rising edge
//   rst_n : asynchronous active-low reset
//   bus   : button_debounce_multi_if slave
//           btn_raw in; level/press/release/long/any_pressed out
module button_debounce_multi #(
  parameter int N_CH          = 4,
  parameter int DEB_CYCLES    = 65536,
  parameter int DEB_W         = 17,
  parameter int LONG_CYCLES   = 25000000,
  parameter int LONG_W        = 25,
  parameter int ACTIVE_LOW    = 1,
  parameter int REPEAT_EN     = 0,
  parameter int REPEAT_CYCLES = 5000000
) (
  input logic                  clk,
  input logic                  rst_n,
  button_debounce_multi_if.slave bus
);

  localparam logic              INACTIVE = (ACTIVE_LOW != 0) ? 1'b1 : 1'b0;
  localparam logic [DEB_W-1:0]  DEB_MAX  = DEB_W'(DEB_CYCLES - 1);
  localparam logic [LONG_W-1:0] LONG_MAX = LONG_W'(LONG_CYCLES - 1);
  localparam logic [LONG_W-1:0] REP_MAX  = LONG_W'(REPEAT_CYCLES - 1);
  localparam logic [LONG_W-1:0] HOLD_SAT = {LONG_W{1'b1}};

  logic [N_CH-1:0]   sync1_q, sync2_q;
  logic [N_CH-1:0]   nrm_s;
  logic [N_CH-1:0]   stable_q, stable_d;
  logic [N_CH-1:0]   press_q, press_d;
  logic [N_CH-1:0]   release_q, release_d;
  logic [N_CH-1:0]   long_q, long_d;
  logic [N_CH-1:0]   long_done_q, long_done_d;
  logic [DEB_W-1:0]  deb_cnt_q [N_CH];
  logic [DEB_W-1:0]  deb_cnt_d [N_CH];
  logic [LONG_W-1:0] hold_cnt_q [N_CH];
  logic [LONG_W-1:0] hold_cnt_d [N_CH];

  // The synchroniser resets to the idle pin level, so a button held through
  // reset looks like a fresh change and is debounced as a normal press.
  assign nrm_s = sync2_q ^ {N_CH{INACTIVE}};

  // Per-channel next state: debounce, event pulses, hold/long/repeat timing.
  always_comb begin
    stable_d    = stable_q;
    long_done_d = long_done_q;
    press_d     = '0;
    release_d   = '0;
    long_d      = '0;
    deb_cnt_d   = deb_cnt_q;
    hold_cnt_d  = hold_cnt_q;
    for (int i = 0; i < N_CH; i++) begin
      if (nrm_s[i] == stable_q[i]) begin
        deb_cnt_d[i] = '0;
      end else if (deb_cnt_q[i] == DEB_MAX) begin
        stable_d[i]  = nrm_s[i];
        deb_cnt_d[i] = '0;
        if (nrm_s[i]) begin
          press_d[i] = 1'b1;
        end else begin
          release_d[i] = 1'b1;
        end
      end else begin
        deb_cnt_d[i] = deb_cnt_q[i] + DEB_W'(1);
      end

      // A release cycle wins over long/repeat so the pulses stay exclusive.
      if (!stable_q[i] || release_d[i]) begin
        hold_cnt_d[i]  = '0;
        long_done_d[i] = 1'b0;
      end else if (!long_done_q[i] && (hold_cnt_q[i] == LONG_MAX)) begin
        long_d[i]      = 1'b1;
        long_done_d[i] = 1'b1;
        // With auto-repeat the hold counter becomes the repeat timer.
        if (REPEAT_EN != 0) begin
          hold_cnt_d[i] = '0;
        end else begin
          hold_cnt_d[i] = hold_cnt_q[i] + LONG_W'(1);
        end
      end else if ((REPEAT_EN != 0) && long_done_q[i] && (hold_cnt_q[i] == REP_MAX)) begin
        press_d[i]    = 1'b1;
        hold_cnt_d[i] = '0;
      end else if (hold_cnt_q[i] != HOLD_SAT) begin
        hold_cnt_d[i] = hold_cnt_q[i] + LONG_W'(1);
      end else begin
        hold_cnt_d[i] = hold_cnt_q[i];
      end
    end
  end

  // State and output registers; reset discards all debounce/hold progress.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q     <= {N_CH{INACTIVE}};
      sync2_q     <= {N_CH{INACTIVE}};
      stable_q    <= '0;
      press_q     <= '0;
      release_q   <= '0;
      long_q      <= '0;
      long_done_q <= '0;
      for (int i = 0; i < N_CH; i++) begin
        deb_cnt_q[i]  <= '0;
        hold_cnt_q[i] <= '0;
      end
    end else begin
      sync1_q     <= bus.btn_raw;
      sync2_q     <= sync1_q;
      stable_q    <= stable_d;
      press_q     <= press_d;
      release_q   <= release_d;
      long_q      <= long_d;
      long_done_q <= long_done_d;
      for (int i = 0; i < N_CH; i++) begin
        deb_cnt_q[i]  <= deb_cnt_d[i];
        hold_cnt_q[i] <= hold_cnt_d[i];
      end
    end
  end

  assign bus.level_o       = stable_q;
  assign bus.press_o       = press_q;
  assign bus.release_o     = release_q;
  assign bus.long_o        = long_q;
  assign bus.any_pressed_o = |stable_q;

endmodule

// File: tb/tb_button_debounce_multi.sv
module tb_button_debounce_multi;
  localparam int N    = 4;
  localparam int DEB  = 16;
  localparam int LONG = 64;
  localparam int REP  = 20;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic [N-1:0] pressed = '0;

  always #5 clk = ~clk;

  button_debounce_multi_if #(.N_CH(N)) bus0 ();
  button_debounce_multi_if #(.N_CH(N)) bus1 ();

  assign bus0.btn_raw = ~pressed;
  assign bus1.btn_raw = ~pressed;

  button_debounce_multi #(
    .N_CH(N), .DEB_CYCLES(DEB), .DEB_W(5), .LONG_CYCLES(LONG), .LONG_W(8),
    .ACTIVE_LOW(1), .REPEAT_EN(0), .REPEAT_CYCLES(REP)
  ) u_dut0 (.clk(clk), .rst_n(rst_n), .bus(bus0));

  button_debounce_multi #(
    .N_CH(N), .DEB_CYCLES(DEB), .DEB_W(5), .LONG_CYCLES(LONG), .LONG_W(8),
    .ACTIVE_LOW(1), .REPEAT_EN(1), .REPEAT_CYCLES(REP)
  ) u_dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1));

  // Reference model: pressed-level history (index 0 = newest sample),
  // accepted level, and edges elapsed since the press was accepted.
  bit           m_hist   [2][N][DEB+1];
  bit           m_stable [2][N];
  int           m_age    [2][N];
  logic [N-1:0] e_press  [2];
  logic [N-1:0] e_rel    [2];
  logic [N-1:0] e_long   [2];

  int n_tests = 0;
  int n_fail  = 0;
  int tick_no = 0;

  task automatic model_step();
    bit accept;
    for (int d = 0; d < 2; d++) begin
      e_press[d] = '0;
      e_rel[d]   = '0;
      e_long[d]  = '0;
      for (int c = 0; c < N; c++) begin
        if (!rst_n) begin
          for (int k = 0; k <= DEB; k++) m_hist[d][c][k] = 1'b0;
          m_stable[d][c] = 1'b0;
          m_age[d][c]    = 0;
        end else begin
          // The logic sees each pin sample two edges late; a change is
          // accepted once DEB consecutive seen values differ from the level.
          accept = 1'b1;
          for (int k = 1; k <= DEB; k++)
            if (m_hist[d][c][k] == m_stable[d][c]) accept = 1'b0;
          if (accept) begin
            m_stable[d][c] = ~m_stable[d][c];
            m_age[d][c]    = 0;
            if (m_stable[d][c]) e_press[d][c] = 1'b1;
            else                e_rel[d][c]   = 1'b1;
          end else if (m_stable[d][c]) begin
            m_age[d][c]++;
            if (m_age[d][c] == LONG)
              e_long[d][c] = 1'b1;
            else if (d == 1 && m_age[d][c] > LONG && ((m_age[d][c] - LONG) % REP) == 0)
              e_press[d][c] = 1'b1;
          end
          for (int k = DEB; k > 0; k--) m_hist[d][c][k] = m_hist[d][c][k-1];
          m_hist[d][c][0] = pressed[c];
        end
      end
    end
  endtask

  function automatic logic [31:0] exp_vec(input int d);
    logic [N-1:0] lv;
    for (int c = 0; c < N; c++) lv[c] = m_stable[d][c];
    return 32'({|lv, e_long[d], e_rel[d], e_press[d], lv});
  endfunction

  function automatic logic [31:0] obs_vec(input int d);
    if (d == 0)
      return 32'({bus0.any_pressed_o, bus0.long_o, bus0.release_o, bus0.press_o, bus0.level_o});
    else
      return 32'({bus1.any_pressed_o, bus1.long_o, bus1.release_o, bus1.press_o, bus1.level_o});
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h (cycle %0d)", tag, obs, exp, tick_no);
    end
  endtask

  // One clock: model updates at the edge, outputs are compared mid-cycle.
  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
    tick_no++;
    chk("model_dut0", obs_vec(0), exp_vec(0));
    chk("model_dut1", obs_vec(1), exp_vec(1));
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  // Ticks until the selected pulse appears on dut d channel c; -1 on timeout.
  // kind: 0 = press, 1 = long, 2 = release.
  task automatic wait_pulse(input int d, input int c, input int kind,
                            input int limit, output int lat);
    logic hit;
    lat = -1;
    for (int t = 1; t <= limit; t++) begin
      tick();
      if (d == 0) hit = (kind == 0) ? bus0.press_o[c] : (kind == 1) ? bus0.long_o[c] : bus0.release_o[c];
      else        hit = (kind == 0) ? bus1.press_o[c] : (kind == 1) ? bus1.long_o[c] : bus1.release_o[c];
      if (hit) begin
        lat = t;
        break;
      end
    end
  endtask

  int   lat;
  int   cnt_a, cnt_b;
  logic seen;
  int   dwell [N];

  initial begin
    // Reset state
    run(3);
    chk("reset_outputs_dut0", obs_vec(0), 32'd0);
    chk("reset_outputs_dut1", obs_vec(1), 32'd0);
    rst_n = 1'b1;
    run(3);

    // 1: single press, exact acceptance latency
    pressed[0] = 1'b1;
    run(DEB + 1);
    chk("t1_level_before", 32'(bus0.level_o[0]), 32'd0);
    tick();
    chk("t1_level_at_18", 32'(bus0.level_o), 32'h1);
    chk("t1_press_at_18", 32'(bus0.press_o), 32'h1);
    chk("t1_any_pressed", 32'(bus0.any_pressed_o), 32'd1);
    tick();
    chk("t1_press_one_cycle", 32'(bus0.press_o), 32'd0);
    pressed[0] = 1'b0;
    wait_pulse(0, 0, 2, 40, lat);
    chk("t1_release_latency", 32'(lat), 32'(DEB + 2));
    run(5);

    // 2: bounces shorter than the debounce window are ignored
    seen = 1'b0;
    for (int r = 0; r < 5; r++) begin
      pressed[1] = 1'b1;
      for (int i = 0; i < 10; i++) begin
        tick();
        seen |= bus0.level_o[1] | bus0.press_o[1] | bus0.release_o[1] | bus1.level_o[1];
      end
      pressed[1] = 1'b0;
      for (int i = 0; i < 10; i++) begin
        tick();
        seen |= bus0.level_o[1] | bus0.press_o[1] | bus0.release_o[1] | bus1.level_o[1];
      end
    end
    chk("t2_glitch_ignored", 32'(seen), 32'd0);

    // 3: long hold without repeat
    pressed[2] = 1'b1;
    wait_pulse(0, 2, 0, 40, lat);
    chk("t3_press_latency", 32'(lat), 32'(DEB + 2));
    cnt_a = 0; cnt_b = 0; lat = -1;
    for (int t = 1; t <= 200; t++) begin
      tick();
      if (bus0.press_o[2]) cnt_a++;
      if (bus0.long_o[2]) begin
        cnt_b++;
        lat = t;
      end
    end
    chk("t3_no_extra_press", 32'(cnt_a), 32'd0);
    chk("t3_long_count", 32'(cnt_b), 32'd1);
    chk("t3_long_at_64", 32'(lat), 32'(LONG));
    pressed[2] = 1'b0;
    wait_pulse(0, 2, 2, 40, lat);
    chk("t3_release_latency", 32'(lat), 32'(DEB + 2));
    chk("t3_level_low", 32'(bus0.level_o[2]), 32'd0);
    run(5);

    // 4: auto-repeat
    pressed[3] = 1'b1;
    wait_pulse(1, 3, 0, 40, lat);
    chk("t4_press_latency", 32'(lat), 32'(DEB + 2));
    wait_pulse(1, 3, 1, 100, lat);
    chk("t4_long_latency", 32'(lat), 32'(LONG));
    cnt_a = 0;
    for (int t = 1; t <= 150; t++) begin
      tick();
      if (bus1.press_o[3]) cnt_a++;
    end
    chk("t4_repeat_count", 32'(cnt_a), 32'd7);
    pressed[3] = 1'b0;
    cnt_b = 0;
    for (int t = 1; t <= 30; t++) begin
      tick();
      if (bus1.release_o[3]) cnt_b++;
    end
    chk("t4_release_count", 32'(cnt_b), 32'd1);
    chk("t4_level_low", 32'(bus1.level_o[3]), 32'd0);
    run(5);

    // 5: simultaneous presses on two channels
    pressed = 4'b1001;
    wait_pulse(0, 0, 0, 40, lat);
    chk("t5_press_latency", 32'(lat), 32'(DEB + 2));
    chk("t5_press_both_dut0", 32'(bus0.press_o), 32'h9);
    chk("t5_press_both_dut1", 32'(bus1.press_o), 32'h9);
    pressed = 4'b0000;
    run(DEB + 8);

    // 6: reset in the middle of a debounce count
    pressed[0] = 1'b1;
    run(12);
    rst_n = 1'b0;
    run(2);
    chk("t6_in_reset", obs_vec(0), 32'd0);
    rst_n = 1'b1;
    wait_pulse(0, 0, 0, 40, lat);
    chk("t6_press_after_reset", 32'(lat), 32'(DEB + 2));
    pressed[0] = 1'b0;
    run(DEB + 8);

    // Random bouncing and holds of mixed length, with occasional reset
    for (int c = 0; c < N; c++) dwell[c] = $urandom_range(1, 120);
    for (int t = 0; t < 4000; t++) begin
      for (int c = 0; c < N; c++) begin
        dwell[c]--;
        if (dwell[c] <= 0) begin
          pressed[c] = ~pressed[c];
          dwell[c]   = ($urandom_range(0, 2) == 0) ? $urandom_range(1, 20)
                                                    : $urandom_range(10, 250);
        end
      end
      rst_n = ($urandom_range(0, 999) == 0) ? 1'b0 : 1'b1;
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
